// File: rtl/lsu_pkg.sv
// Shared definitions for the DataM load/store master: funct3 codes,
// FSM state encoding and request-legality helpers.
package lsu_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_LB  = 3'b000, F3_LH  = 3'b001, F3_LW = 3'b010,
                          F3_LBU = 3'b100, F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000, F3_SH  = 3'b001, F3_SW = 3'b010;

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   // RV32I loads use 000/001/010/100/101; stores only 000/001/010.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      if (we) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
   endfunction

   // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
      case (f3[1:0])
         2'b01:   return lo[0];
         2'b10:   return lo != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Request/response and DataM signal bundle of the load/store master.
// master: the LSU itself; slave: the pipeline plus DataM environment.
interface lsu_mem_master_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
   );

   modport slave (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
   );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: little-endian byte/half extraction with
// sign or zero extension for loads, and lane merge for SB/SH.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [1:0]      lane,
   input  logic [XLEN-1:0] rdata,
   input  logic [15:0]     wdata,
   output logic [XLEN-1:0] load_data,
   output logic [XLEN-1:0] merged
);

   logic signed [7:0]      byte_s;
   logic signed [15:0]     half_s;
   logic signed [XLEN-1:0] byte_ext;
   logic signed [XLEN-1:0] half_ext;

   assign byte_s   = rdata[8*lane +: 8];
   assign half_s   = lane[1] ? rdata[31:16] : rdata[15:0];
   assign byte_ext = byte_s;
   assign half_ext = half_s;

   // Select the extended load value from funct3 (LW passes the word through)
   always_comb begin
      load_data = rdata;
      case (funct3)
         F3_LB:   load_data = byte_ext;
         F3_LH:   load_data = half_ext;
         F3_LBU:  load_data = {24'b0, byte_s};
         F3_LHU:  load_data = {16'b0, half_s};
         default: load_data = rdata;
      endcase
   end

   // Replace only the addressed lane(s) of the read word with store data
   always_comb begin
      merged = rdata;
      if (funct3[1:0] == 2'b00)
         merged[8*lane +: 8] = wdata[7:0];
      else if (funct3[1:0] == 2'b01)
         merged[16*lane[1] +: 16] = wdata[15:0];
   end

endmodule

// File: rtl/lsu_mem_master.sv
// RV32I load/store master for the word-only DataM port.
// Optional feature: define MISALIGN_TRAP_EN to turn misaligned LH/LHU/SH/LW/SW
// into error responses; otherwise low address bits are truncated.
module lsu_mem_master
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = XLEN
) (
   input logic CLK,
   input logic RST,
   lsu_mem_master_if.master bus
);

   state_t            state, state_nx;
   logic              accept;
   logic              req_err;
   logic              mis;
   logic              we_q;
   logic              err_q;
   logic [2:0]        f3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] wdata_out_q;
   logic [DATA_W-1:0] load_data;
   logic [DATA_W-1:0] merged;

   assign accept = bus.req_valid && (state == IDLE);

`ifdef MISALIGN_TRAP_EN
   assign mis = f3_misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
   assign mis = 1'b0;
`endif

   assign req_err = !f3_legal(bus.req_we, bus.req_funct3) || mis;

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state decode and per-state strobes; strobes depend only on state so reset clears them at once
   always_comb begin
      state_nx       = state;
      bus.req_ready  = 1'b0;
      bus.mem_we     = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_err   = 1'b0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               if (req_err)                                  state_nx = RESP;
               else if (bus.req_we && bus.req_funct3 == F3_SW) state_nx = WR;
               else                                          state_nx = RD;
            end
         end
         RD:   state_nx = we_q ? WR : RESP;
         WR: begin
            bus.mem_we = 1'b1;
            state_nx   = RESP;
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            bus.resp_err   = err_q;
            state_nx       = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Capture the request, then sample DataM at the end of RD into either the load result or the merged store word
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         we_q        <= 1'b0;
         err_q       <= 1'b0;
         f3_q        <= 3'b000;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         wdata_out_q <= '0;
      end else if (accept) begin
         we_q        <= bus.req_we;
         err_q       <= req_err;
         f3_q        <= bus.req_funct3;
         addr_q      <= bus.req_addr;
         wdata_q     <= bus.req_wdata[15:0];
         rdata_q     <= '0;
         wdata_out_q <= bus.req_wdata;
      end else if (state == RD) begin
         if (we_q) wdata_out_q <= merged;
         else      rdata_q     <= load_data;
      end
   end

   assign bus.mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
   assign bus.mem_wdata  = wdata_out_q;
   assign bus.resp_rdata = rdata_q;

   lsu_align u_align (
      .funct3    (f3_q),
      .lane      (addr_q[1:0]),
      .rdata     (bus.mem_rdata),
      .wdata     (wdata_q),
      .load_data (load_data),
      .merged    (merged)
   );

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: a small word memory stands in for DataM,
// expected responses are queued as each request is driven and popped on completion.
module tb_lsu_mem_master;
   import lsu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   lsu_mem_master_if bus ();

   lsu_mem_master dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   // DataM model: combinational read, write on posedge
   logic [31:0] mem [0:63];
   always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
   assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          wes;
      logic [31:0] wa;
      logic [31:0] wd;
   } vec_t;

   vec_t sb_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   logic        got;
   int          lat;
   int          wes;
   logic [31:0] o_rd, o_wa, o_wd;
   logic        o_err;

   // Drive one request, release it after acceptance, observe until the response (bounded)
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      got = 1'b0; lat = 0; wes = 0;
      o_rd = '0; o_err = 1'b0; o_wa = '0; o_wd = '0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (bus.mem_we) begin wes++; o_wa = bus.mem_addr; o_wd = bus.mem_wdata; end
         if (bus.resp_valid) begin
            got = 1'b1; lat = i; o_rd = bus.resp_rdata; o_err = bus.resp_err;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      n_chk++; if (bus.req_ready !== 1'b1)   begin n_fail++; $display("FAIL rst req_ready: got %b required 1", bus.req_ready); end
      n_chk++; if (bus.resp_valid !== 1'b0)  begin n_fail++; $display("FAIL rst resp_valid: got %b required 0", bus.resp_valid); end
      n_chk++; if (bus.resp_err !== 1'b0)    begin n_fail++; $display("FAIL rst resp_err: got %b required 0", bus.resp_err); end
      n_chk++; if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst resp_rdata: got %h required 0", bus.resp_rdata); end
      n_chk++; if (bus.mem_we !== 1'b0)      begin n_fail++; $display("FAIL rst mem_we: got %b required 0", bus.mem_we); end
      n_chk++; if (bus.mem_addr !== 32'h0)   begin n_fail++; $display("FAIL rst mem_addr: got %h required 0", bus.mem_addr); end
      n_chk++; if (bus.mem_wdata !== 32'h0)  begin n_fail++; $display("FAIL rst mem_wdata: got %h required 0", bus.mem_wdata); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_sw_lw();
      vec_t v[$];
      vec_t e;
      v.push_back('{1'b1, F3_SW, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'h10, 32'hDEADBEEF});
      v.push_back('{1'b0, F3_LW, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 32'h0,  32'h0});
      foreach (v[i]) begin
         sb_q.push_back(v[i]);
         issue(v[i].we, v[i].f3, v[i].addr, v[i].wdata);
         e = sb_q.pop_front();
         n_chk++; if (got !== 1'b1)      begin n_fail++; $display("FAIL sw_lw[%0d] resp_valid: not observed within 8 cycles, required 1", i); end
         n_chk++; if (lat != e.lat)      begin n_fail++; $display("FAIL sw_lw[%0d] latency: got %0d required %0d", i, lat, e.lat); end
         n_chk++; if (o_rd !== e.rdata)  begin n_fail++; $display("FAIL sw_lw[%0d] resp_rdata: got %h required %h", i, o_rd, e.rdata); end
         n_chk++; if (o_err !== e.err)   begin n_fail++; $display("FAIL sw_lw[%0d] resp_err: got %b required %b", i, o_err, e.err); end
         n_chk++; if (wes != e.wes)      begin n_fail++; $display("FAIL sw_lw[%0d] mem_we cycles: got %0d required %0d", i, wes, e.wes); end
         if (e.wes > 0) begin
            n_chk++; if (o_wa !== e.wa)  begin n_fail++; $display("FAIL sw_lw[%0d] mem_addr: got %h required %h", i, o_wa, e.wa); end
            n_chk++; if (o_wd !== e.wd)  begin n_fail++; $display("FAIL sw_lw[%0d] mem_wdata: got %h required %h", i, o_wd, e.wd); end
         end
      end
   endtask

   task automatic test_load_ext();
      vec_t v[$];
      vec_t e;
      v.push_back('{1'b0, F3_LB,  32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 0, 32'h0, 32'h0});
      v.push_back('{1'b0, F3_LBU, 32'h13, 32'h0, 32'h000000DE, 1'b0, 2, 0, 32'h0, 32'h0});
      v.push_back('{1'b0, F3_LH,  32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 2, 0, 32'h0, 32'h0});
      v.push_back('{1'b0, F3_LHU, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 2, 0, 32'h0, 32'h0});
      v.push_back('{1'b0, F3_LB,  32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, 2, 0, 32'h0, 32'h0});
      v.push_back('{1'b0, F3_LBU, 32'h11, 32'h0, 32'h000000BE, 1'b0, 2, 0, 32'h0, 32'h0});
      foreach (v[i]) begin
         sb_q.push_back(v[i]);
         issue(v[i].we, v[i].f3, v[i].addr, v[i].wdata);
         e = sb_q.pop_front();
         n_chk++; if (got !== 1'b1)      begin n_fail++; $display("FAIL ld_ext[%0d] resp_valid: not observed within 8 cycles, required 1", i); end
         n_chk++; if (lat != e.lat)      begin n_fail++; $display("FAIL ld_ext[%0d] latency: got %0d required %0d", i, lat, e.lat); end
         n_chk++; if (o_rd !== e.rdata)  begin n_fail++; $display("FAIL ld_ext[%0d] resp_rdata: got %h required %h", i, o_rd, e.rdata); end
         n_chk++; if (o_err !== e.err)   begin n_fail++; $display("FAIL ld_ext[%0d] resp_err: got %b required %b", i, o_err, e.err); end
         n_chk++; if (wes != e.wes)      begin n_fail++; $display("FAIL ld_ext[%0d] mem_we cycles: got %0d required %0d", i, wes, e.wes); end
      end
   endtask

   task automatic test_store_merge();
      vec_t v[$];
      vec_t e;
      v.push_back('{1'b1, F3_SB, 32'h11, 32'h00000055, 32'h0,        1'b0, 3, 1, 32'h10, 32'hDEAD55EF});
      v.push_back('{1'b1, F3_SH, 32'h12, 32'hAAAA1234, 32'h0,        1'b0, 3, 1, 32'h10, 32'h123455EF});
      v.push_back('{1'b0, F3_LW, 32'h10, 32'h0,        32'h123455EF, 1'b0, 2, 0, 32'h0,  32'h0});
      v.push_back('{1'b0, F3_LH, 32'h12, 32'h0,        32'h00001234, 1'b0, 2, 0, 32'h0,  32'h0});
      foreach (v[i]) begin
         sb_q.push_back(v[i]);
         issue(v[i].we, v[i].f3, v[i].addr, v[i].wdata);
         e = sb_q.pop_front();
         n_chk++; if (got !== 1'b1)      begin n_fail++; $display("FAIL merge[%0d] resp_valid: not observed within 8 cycles, required 1", i); end
         n_chk++; if (lat != e.lat)      begin n_fail++; $display("FAIL merge[%0d] latency: got %0d required %0d", i, lat, e.lat); end
         n_chk++; if (o_rd !== e.rdata)  begin n_fail++; $display("FAIL merge[%0d] resp_rdata: got %h required %h", i, o_rd, e.rdata); end
         n_chk++; if (o_err !== e.err)   begin n_fail++; $display("FAIL merge[%0d] resp_err: got %b required %b", i, o_err, e.err); end
         n_chk++; if (wes != e.wes)      begin n_fail++; $display("FAIL merge[%0d] mem_we cycles: got %0d required %0d", i, wes, e.wes); end
         if (e.wes > 0) begin
            n_chk++; if (o_wa !== e.wa)  begin n_fail++; $display("FAIL merge[%0d] mem_addr: got %h required %h", i, o_wa, e.wa); end
            n_chk++; if (o_wd !== e.wd)  begin n_fail++; $display("FAIL merge[%0d] mem_wdata: got %h required %h", i, o_wd, e.wd); end
         end
      end
   endtask

   task automatic test_illegal();
      vec_t v[$];
      vec_t e;
      v.push_back('{1'b0, 3'b111, 32'h10, 32'h0,        32'h0, 1'b1, 1, 0, 32'h0, 32'h0});
      v.push_back('{1'b0, 3'b011, 32'h10, 32'h0,        32'h0, 1'b1, 1, 0, 32'h0, 32'h0});
      v.push_back('{1'b0, 3'b110, 32'h10, 32'h0,        32'h0, 1'b1, 1, 0, 32'h0, 32'h0});
      v.push_back('{1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0});
      v.push_back('{1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0});
      foreach (v[i]) begin
         sb_q.push_back(v[i]);
         issue(v[i].we, v[i].f3, v[i].addr, v[i].wdata);
         e = sb_q.pop_front();
         n_chk++; if (got !== 1'b1)      begin n_fail++; $display("FAIL illegal[%0d] resp_valid: not observed within 8 cycles, required 1", i); end
         n_chk++; if (lat != e.lat)      begin n_fail++; $display("FAIL illegal[%0d] latency: got %0d required %0d", i, lat, e.lat); end
         n_chk++; if (o_rd !== e.rdata)  begin n_fail++; $display("FAIL illegal[%0d] resp_rdata: got %h required %h", i, o_rd, e.rdata); end
         n_chk++; if (o_err !== e.err)   begin n_fail++; $display("FAIL illegal[%0d] resp_err: got %b required %b", i, o_err, e.err); end
         n_chk++; if (wes != e.wes)      begin n_fail++; $display("FAIL illegal[%0d] mem_we cycles: got %0d required %0d", i, wes, e.wes); end
      end
   endtask

   task automatic test_misalign();
      vec_t v[$];
      vec_t e;
`ifdef MISALIGN_TRAP_EN
      v.push_back('{1'b0, F3_LW, 32'h12, 32'h0,        32'h0, 1'b1, 1, 0, 32'h0, 32'h0});
      v.push_back('{1'b0, F3_LH, 32'h11, 32'h0,        32'h0, 1'b1, 1, 0, 32'h0, 32'h0});
      v.push_back('{1'b1, F3_SW, 32'h31, 32'h0BADF00D, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0});
`else
      v.push_back('{1'b0, F3_LW, 32'h12, 32'h0,        32'h123455EF, 1'b0, 2, 0, 32'h0,  32'h0});
      v.push_back('{1'b0, F3_LH, 32'h11, 32'h0,        32'h000055EF, 1'b0, 2, 0, 32'h0,  32'h0});
      v.push_back('{1'b1, F3_SW, 32'h31, 32'h0BADF00D, 32'h0,        1'b0, 2, 1, 32'h30, 32'h0BADF00D});
`endif
      foreach (v[i]) begin
         sb_q.push_back(v[i]);
         issue(v[i].we, v[i].f3, v[i].addr, v[i].wdata);
         e = sb_q.pop_front();
         n_chk++; if (got !== 1'b1)      begin n_fail++; $display("FAIL misalign[%0d] resp_valid: not observed within 8 cycles, required 1", i); end
         n_chk++; if (lat != e.lat)      begin n_fail++; $display("FAIL misalign[%0d] latency: got %0d required %0d", i, lat, e.lat); end
         n_chk++; if (o_rd !== e.rdata)  begin n_fail++; $display("FAIL misalign[%0d] resp_rdata: got %h required %h", i, o_rd, e.rdata); end
         n_chk++; if (o_err !== e.err)   begin n_fail++; $display("FAIL misalign[%0d] resp_err: got %b required %b", i, o_err, e.err); end
         n_chk++; if (wes != e.wes)      begin n_fail++; $display("FAIL misalign[%0d] mem_we cycles: got %0d required %0d", i, wes, e.wes); end
         if (e.wes > 0) begin
            n_chk++; if (o_wa !== e.wa)  begin n_fail++; $display("FAIL misalign[%0d] mem_addr: got %h required %h", i, o_wa, e.wa); end
            n_chk++; if (o_wd !== e.wd)  begin n_fail++; $display("FAIL misalign[%0d] mem_wdata: got %h required %h", i, o_wd, e.wd); end
         end
      end
   endtask

   task automatic test_reset_mid_write();
      vec_t v[$];
      vec_t e;
      int   stray;
      issue(1'b1, F3_SW, 32'h20, 32'hA5A5A5A5);
      n_chk++; if (got !== 1'b1) begin n_fail++; $display("FAIL rst_mid setup store: no response observed, required one"); end
      // SB to 0x20: accept, RD, then reset in the middle of WR
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_SB;
      bus.req_addr = 32'h20; bus.req_wdata = 32'h00000011;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_chk++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL rst_mid WR reached: mem_we got %b required 1", bus.mem_we); end
      #1 rst = 1'b1;
      #1;
      n_chk++; if (bus.mem_we !== 1'b0)     begin n_fail++; $display("FAIL rst_mid mem_we: got %b required 0", bus.mem_we); end
      n_chk++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid resp_valid: got %b required 0", bus.resp_valid); end
      n_chk++; if (bus.req_ready !== 1'b1)  begin n_fail++; $display("FAIL rst_mid req_ready: got %b required 1", bus.req_ready); end
      @(negedge clk);
      rst = 1'b0;
      stray = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.resp_valid) stray++;
      end
      n_chk++; if (stray != 0) begin n_fail++; $display("FAIL rst_mid stray resp_valid: got %0d cycles required 0", stray); end
      v.push_back('{1'b0, F3_LW, 32'h20, 32'h0,        32'hA5A5A5A5, 1'b0, 2, 0, 32'h0,  32'h0});
      v.push_back('{1'b1, F3_SW, 32'h24, 32'h01020304, 32'h0,        1'b0, 2, 1, 32'h24, 32'h01020304});
      v.push_back('{1'b0, F3_LW, 32'h24, 32'h0,        32'h01020304, 1'b0, 2, 0, 32'h0,  32'h0});
      foreach (v[i]) begin
         sb_q.push_back(v[i]);
         issue(v[i].we, v[i].f3, v[i].addr, v[i].wdata);
         e = sb_q.pop_front();
         n_chk++; if (got !== 1'b1)      begin n_fail++; $display("FAIL rst_mid[%0d] resp_valid: not observed within 8 cycles, required 1", i); end
         n_chk++; if (lat != e.lat)      begin n_fail++; $display("FAIL rst_mid[%0d] latency: got %0d required %0d", i, lat, e.lat); end
         n_chk++; if (o_rd !== e.rdata)  begin n_fail++; $display("FAIL rst_mid[%0d] resp_rdata: got %h required %h", i, o_rd, e.rdata); end
         n_chk++; if (o_err !== e.err)   begin n_fail++; $display("FAIL rst_mid[%0d] resp_err: got %b required %b", i, o_err, e.err); end
         n_chk++; if (wes != e.wes)      begin n_fail++; $display("FAIL rst_mid[%0d] mem_we cycles: got %0d required %0d", i, wes, e.wes); end
         if (e.wes > 0) begin
            n_chk++; if (o_wa !== e.wa)  begin n_fail++; $display("FAIL rst_mid[%0d] mem_addr: got %h required %h", i, o_wa, e.wa); end
            n_chk++; if (o_wd !== e.wd)  begin n_fail++; $display("FAIL rst_mid[%0d] mem_wdata: got %h required %h", i, o_wd, e.wd); end
         end
      end
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      test_reset();
      test_sw_lw();
      test_load_ext();
      test_store_merge();
      test_illegal();
      test_misalign();
      test_reset_mid_write();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached before the end of the sequence");
      $fatal(1, "watchdog");
   end

endmodule
